// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line into the receiver and the frame-level results out of it.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
    logic                 i_Rx_Serial;
    logic                 o_Rx_Dv;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    modport master (output i_Rx_Serial, input o_Rx_Dv, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break);
    modport slave  (input i_Rx_Serial, output o_Rx_Dv, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting and parity/framing/break flags.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input logic          i_Clock,
    input logic          i_Reset,
    uart_rx_cfg_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 meta_q, rx_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 stop_idx_q, stop_idx_d, st0_q, st0_d, par_q, par_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
    logic                 dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic                 maj, decide, at_end, last_stop, perr, ferr, brk;

    assign maj       = (s0_q & s1_q) | (s0_q & rx_q) | (s1_q & rx_q);
    assign decide    = cnt_q == MID + 1'b1;
    assign at_end    = cnt_q == LAST;
    assign last_stop = STOP_BITS == 1 || stop_idx_q;
    // Flags as they would be latched if the current stop decision is the final one.
    assign perr = PARITY != 0 && (^{shift_q, par_q}) == (PARITY == 2);
    assign ferr = !maj || (STOP_BITS == 2 && !st0_q);
    assign brk  = shift_q == '0 && (PARITY == 0 || !par_q) && !maj && (STOP_BITS == 1 || !st0_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        s0_d       = cnt_q == MID - 1'b1 ? rx_q : s0_q;
        s1_d       = cnt_q == MID ? rx_q : s1_q;
        stop_idx_d = stop_idx_q;
        st0_d      = st0_q;
        par_d      = par_q;
        shift_d    = shift_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_q ? IDLE : START;
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (decide) shift_d[idx_q] = maj;
                if (at_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d    = PARITY == 0 ? STOP : PAR;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            PAR: begin
                if (decide) par_d = maj;
                if (at_end) begin
                    state_d    = STOP;
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (decide && last_stop) begin
                    dv_d    = 1'b1;
                    byte_d  = shift_q;
                    perr_d  = perr;
                    ferr_d  = ferr;
                    brk_d   = brk;
                    state_d = brk ? BRK_WAIT : IDLE;
                    cnt_d   = '0;
                end else if (decide) begin
                    st0_d = maj;
                end else if (at_end) begin
                    stop_idx_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            BRK_WAIT: begin
                cnt_d   = '0;
                state_d = rx_q ? IDLE : BRK_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            meta_q     <= 1'b1;
            rx_q       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            st0_q      <= 1'b0;
            par_q      <= 1'b0;
            shift_q    <= '0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            meta_q     <= bus.i_Rx_Serial;
            rx_q       <= meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            stop_idx_q <= stop_idx_d;
            st0_q      <= st0_d;
            par_q      <= par_d;
            shift_q    <= shift_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.o_Rx_Dv      = dv_q;
    assign bus.o_Rx_Byte    = byte_q;
    assign bus.o_Parity_Err = perr_q;
    assign bus.o_Frame_Err  = ferr_q;
    assign bus.o_Break      = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into an 8N1 and a 7O2 receiver, both at 16 clocks per bit.
module tb_uart_rx_cfg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ser = 2'b11;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          dv_n[2] = '{0, 0};
    int          dv_cyc[2] = '{0, 0};
    int          dbl = 0;
    logic [1:0]  dv_prev = 2'b00;
    logic [11:0] log8[$];
    logic [11:0] log7[$];

    uart_rx_cfg_if #(.DATA_BITS(8)) if8();
    uart_rx_cfg_if #(.DATA_BITS(7)) if7();
    assign if8.i_Rx_Serial = ser[0];
    assign if7.i_Rx_Serial = ser[1];

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
        .i_Clock(clk), .i_Reset(rst), .bus(if8));
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut7 (
        .i_Clock(clk), .i_Reset(rst), .bus(if7));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if8.o_Rx_Dv) begin
            dv_n[0]++;
            dv_cyc[0] = cyc;
            log8.push_back({if8.o_Break, if8.o_Frame_Err, if8.o_Parity_Err, 1'b0, if8.o_Rx_Byte});
        end
        if (if7.o_Rx_Dv) begin
            dv_n[1]++;
            dv_cyc[1] = cyc;
            log7.push_back({if7.o_Break, if7.o_Frame_Err, if7.o_Parity_Err, 2'b00, if7.o_Rx_Byte});
        end
        if ((if8.o_Rx_Dv && dv_prev[0]) || (if7.o_Rx_Dv && dv_prev[1])) dbl++;
        dv_prev = {if7.o_Rx_Dv, if8.o_Rx_Dv};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        ser[sel] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // par < 0 means no parity bit; spike >= 0 inverts that data bit for one cycle at its mid-point.
    task automatic send(input int sel, input logic [8:0] d, input int nb, input int par,
                        input int ns, input logic sv, input int last_len, input int spike);
        drive(sel, 1'b0, 16);
        for (int i = 0; i < nb; i++) begin
            if (i == spike) begin
                drive(sel, d[i], 8);
                drive(sel, !d[i], 1);
                drive(sel, d[i], 7);
            end else begin
                drive(sel, d[i], 16);
            end
        end
        if (par >= 0) drive(sel, par[0], 16);
        for (int i = 0; i < ns; i++) drive(sel, sv, i == ns - 1 ? last_len : 16);
    endtask

    task automatic expect_frame(input string tag, input int sel, input logic [8:0] b,
                                input logic pe, input logic fe, input logic bk);
        logic [11:0] e;
        int n;
        n = sel == 1 ? log7.size() : log8.size();
        check({tag, "_present"}, n > 0, 1);
        if (n > 0) begin
            if (sel == 1) e = log7.pop_front();
            else e = log8.pop_front();
            check({tag, "_byte"}, e[8:0], b);
            check({tag, "_perr"}, e[9], pe);
            check({tag, "_ferr"}, e[10], fe);
            check({tag, "_brk"}, e[11], bk);
        end
    endtask

    initial begin
        int c, n0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b1, 5);
        check("rst_dv8", if8.o_Rx_Dv, 0);
        check("rst_byte8", if8.o_Rx_Byte, 0);
        check("rst_flags8", {if8.o_Break, if8.o_Frame_Err, if8.o_Parity_Err}, 0);
        check("rst_byte7", if7.o_Rx_Byte, 0);

        c = cyc;
        send(0, 9'h37, 8, -1, 1, 1'b1, 16, -1);
        drive(0, 1'b1, 20);
        check("b8n1_count", dv_n[0], 1);
        check("b8n1_dv_cycle", dv_cyc[0], c + 156);
        expect_frame("b8n1", 0, 9'h37, 0, 0, 0);

        c = cyc;
        send(1, 9'h55, 7, 1, 2, 1'b1, 16, -1);
        drive(1, 1'b1, 20);
        check("p7o2_dv_cycle", dv_cyc[1], c + 172);
        expect_frame("p7o2_ok", 1, 9'h55, 0, 0, 0);
        send(1, 9'h55, 7, 0, 2, 1'b1, 16, -1);
        drive(1, 1'b1, 20);
        check("p7o2_count", dv_n[1], 2);
        expect_frame("p7o2_bad", 1, 9'h55, 1, 0, 0);

        n0 = dv_n[0];
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        check("glitch_no_dv", dv_n[0], n0);
        c = cyc;
        send(0, 9'h5A, 8, -1, 1, 1'b1, 16, -1);
        drive(0, 1'b1, 20);
        check("after_glitch_dv_cycle", dv_cyc[0], c + 156);
        expect_frame("after_glitch", 0, 9'h5A, 0, 0, 0);
        send(0, 9'hA5, 8, -1, 1, 1'b1, 16, 2);
        drive(0, 1'b1, 20);
        expect_frame("spike", 0, 9'hA5, 0, 0, 0);

        n0 = dv_n[0];
        send(0, 9'hF0, 8, -1, 1, 1'b0, 16, -1);
        drive(0, 1'b1, 40);
        check("ferr_count", dv_n[0], n0 + 1);
        expect_frame("ferr", 0, 9'hF0, 0, 1, 0);

        n0 = dv_n[0];
        drive(0, 1'b0, 320);
        check("break_count", dv_n[0], n0 + 1);
        drive(0, 1'b1, 40);
        check("break_no_extra", dv_n[0], n0 + 1);
        expect_frame("break", 0, 9'h00, 0, 1, 1);
        send(0, 9'h81, 8, -1, 1, 1'b1, 16, -1);
        drive(0, 1'b1, 20);
        expect_frame("after_break", 0, 9'h81, 0, 0, 0);

        n0 = dv_n[0];
        send(0, 9'h01, 8, -1, 1, 1'b1, 12, -1);
        send(0, 9'h02, 8, -1, 1, 1'b1, 12, -1);
        send(0, 9'h03, 8, -1, 1, 1'b1, 12, -1);
        drive(0, 1'b1, 40);
        check("b2b_count", dv_n[0], n0 + 3);
        expect_frame("b2b_1", 0, 9'h01, 0, 0, 0);
        expect_frame("b2b_2", 0, 9'h02, 0, 0, 0);
        expect_frame("b2b_3", 0, 9'h03, 0, 0, 0);

        // 0x3C LSB first: 0,0,1,1 then reset part-way through bit 4; the line is released afterwards.
        n0 = dv_n[0];
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b1, 16);
        drive(0, 1'b1, 8);
        rst = 1'b1;
        drive(0, 1'b1, 1);
        rst = 1'b0;
        drive(0, 1'b1, 60);
        check("mrst_no_dv", dv_n[0], n0);
        check("mrst_byte", if8.o_Rx_Byte, 0);
        check("mrst_flags", {if8.o_Break, if8.o_Frame_Err, if8.o_Parity_Err}, 0);
        c = cyc;
        send(0, 9'hC3, 8, -1, 1, 1'b1, 16, -1);
        drive(0, 1'b1, 20);
        check("mrst_next_dv_cycle", dv_cyc[0], c + 156);
        expect_frame("mrst_next", 0, 9'hC3, 0, 0, 0);

        check("dv_single_cycle", dbl, 0);
        check("log8_empty", log8.size(), 0);
        check("log7_empty", log7.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
